// File: rtl/alarm_ring_controller.sv
// alarm_ring_controller: arm/ring/snooze/timeout sequencer for the alarm; snooze support compiled in with ALARM_SNOOZE_EN
module alarm_ring_controller #(
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_SEC   = 300,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz_i,
  input  logic [4:0] time_hh_i,
  input  logic [5:0] time_mm_i,
  input  logic [4:0] alarm_hh_i,
  input  logic [5:0] alarm_mm_i,
  input  logic       hold_i,
  input  logic       arm_tgl_i,
  input  logic       dismiss_i,
  input  logic       snooze_i,
  output logic       armed_o,
  output logic       ringing_o,
  output logic       buzzer_o,
  output logic       snoozing_o,
  output logic [1:0] snooze_used_o
);
  localparam int RW = $clog2(RING_TIMEOUT + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT);
  localparam logic [2:0] S_DISARMED = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_RING     = 3'd2;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;
`ifdef ALARM_SNOOZE_EN
  localparam logic [2:0] S_SNOOZE = 3'd3;
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_SEC);
  localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZE);
`endif
  logic [2:0]    state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d, ring_inc;
  logic          armed_q, ringing_q, buzzer_q;
  logic          beat_d, stop, match, in_event;
  assign match     = (time_hh_i == alarm_hh_i) && (time_mm_i == alarm_mm_i);
  assign ring_inc  = ring_cnt_q + 1'b1;
  assign armed_o   = armed_q;
  assign ringing_o = ringing_q;
  assign buzzer_o  = buzzer_q;
`ifdef ALARM_SNOOZE_EN
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [1:0]    used_q, used_d;
  logic          snoozing_q;
  assign stop          = dismiss_i;
  assign in_event      = (state_q == S_RING) || (state_q == S_SNOOZE);
  assign snoozing_o    = snoozing_q;
  assign snooze_used_o = used_q;
`else
  logic [1:0] unused_cfg;
  assign unused_cfg    = {SNOOZE_SEC[0], MAX_SNOOZE[0]};
  assign stop          = dismiss_i | snooze_i;
  assign in_event      = state_q == S_RING;
  assign snoozing_o    = 1'b0;
  assign snooze_used_o = 2'b0;
`endif
  // next state and counters; buttons outrank the tick, and a winning button discards a coincident tick
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    beat_d     = buzzer_q;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
    used_d       = used_q;
`endif
    if (arm_tgl_i) begin
      state_d    = (state_q == S_DISARMED) ? S_ARMED : S_DISARMED;
      ring_cnt_d = '0;
      beat_d     = 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_d = '0;
      used_d       = '0;
`endif
    end else if (stop && in_event) begin
      state_d = S_LOCKOUT;
    end
`ifdef ALARM_SNOOZE_EN
    else if (snooze_i && state_q == S_RING && used_q < SNOOZE_MAX) begin
      state_d      = S_SNOOZE;
      snooze_cnt_d = SNOOZE_LOAD;
      used_d       = used_q + 1'b1;
    end
`endif
    else begin
      case (state_q)
        S_ARMED: if (match && !hold_i) begin
          state_d    = S_RING;
          ring_cnt_d = '0;
          beat_d     = 1'b1;
`ifdef ALARM_SNOOZE_EN
          used_d     = '0;
`endif
        end
        S_RING: if (tick_1hz_i) begin
          ring_cnt_d = ring_inc;
          beat_d     = !buzzer_q;
          state_d    = (ring_inc == RING_LAST) ? S_LOCKOUT : S_RING;
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: if (tick_1hz_i) begin
          snooze_cnt_d = snooze_cnt_q - 1'b1;
          if (snooze_cnt_q == SW'(1)) begin
            state_d    = S_RING;
            ring_cnt_d = '0;
            beat_d     = 1'b1;
          end
        end
`endif
        S_LOCKOUT: state_d = match ? S_LOCKOUT : S_ARMED;
        default: ;
      endcase
    end
  end
  // state, ring counter and registered outputs decoded from the next state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= S_DISARMED;
      ring_cnt_q <= '0;
      armed_q    <= 1'b0;
      ringing_q  <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      armed_q    <= state_d != S_DISARMED;
      ringing_q  <= state_d == S_RING;
      buzzer_q   <= beat_d && (state_d == S_RING);
    end
`ifdef ALARM_SNOOZE_EN
  // snooze countdown, per-event snooze count and snoozing flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snooze_cnt_q <= '0;
      used_q       <= '0;
      snoozing_q   <= 1'b0;
    end else begin
      snooze_cnt_q <= snooze_cnt_d;
      used_q       <= used_d;
      snoozing_q   <= state_d == S_SNOOZE;
    end
`endif
endmodule
